// File: rtl/alu_txn_driver.sv
// Initiator for the 8-bit combinational ALU port: takes commands from a valid/ready
// stream, drives registered operands, captures result/flags after SETTLE cycles.
module alu_txn_driver #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [7:0]       alu_y,
    input  logic             alu_parity,
    input  logic             alu_overflow,
    input  logic             alu_greater,
    input  logic             alu_is_eq,
    input  logic             alu_less,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_y,
    output logic [4:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TXN_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    // Compare flags are consistent only when exactly one of greater/is_eq/less is set.
    function automatic logic cmp_inconsistent(input logic g, input logic e, input logic l);
        logic [1:0] sum;
        sum = {1'b0, g} + {1'b0, e} + {1'b0, l};
        return (sum != 2'd1);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       settle_cnt_r;
    logic             cmd_ready_r;
    logic             accept_s;
    logic             capture_s;
    logic             handshake_s;
    logic [7:0]       alu_a_r;
    logic [7:0]       alu_b_r;
    logic [1:0]       alu_op_r;
    logic             rsp_valid_r;
    logic [7:0]       rsp_y_r;
    logic [4:0]       rsp_flags_r;
    logic             rsp_err_r;
    logic [CNT_W-1:0] txn_cnt_r;
    logic [7:0]       err_cnt_r;

    // Next-state and per-cycle event decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (settle_cnt_r == 4'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    handshake_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, settle counter and registered cmd_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 4'd0;
            cmd_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            if (accept_s) begin
                settle_cnt_r <= SETTLE_LOAD;
            end else if ((state_r == ST_WAIT) && (settle_cnt_r != 4'd0)) begin
                settle_cnt_r <= settle_cnt_r - 4'd1;
            end
        end
    end

    // Operand registers: loaded only when a command is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_r  <= 8'd0;
            alu_b_r  <= 8'd0;
            alu_op_r <= 2'd0;
        end else if (accept_s) begin
            alu_a_r  <= cmd_a;
            alu_b_r  <= cmd_b;
            alu_op_r <= cmd_op;
        end
    end

    // Response capture; payload holds until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_y_r     <= 8'd0;
            rsp_flags_r <= 5'd0;
            rsp_err_r   <= 1'b0;
        end else if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_y_r     <= alu_y;
            rsp_flags_r <= {alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less};
            rsp_err_r   <= cmp_inconsistent(alu_greater, alu_is_eq, alu_less);
        end else if (handshake_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Completion counters: txn wraps, err saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt_r <= '0;
            err_cnt_r <= 8'd0;
        end else if (handshake_s) begin
            txn_cnt_r <= txn_cnt_r + TXN_ONE;
            if (rsp_err_r && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_y     = rsp_y_r;
    assign rsp_flags = rsp_flags_r;
    assign rsp_err   = rsp_err_r;
    assign txn_cnt   = txn_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_alu_txn_driver.sv
// Directed bench for alu_txn_driver: SETTLE=1/CNT_W=16 instance and a
// SETTLE=3/CNT_W=4 instance (small counter so the wrap is reachable quickly).
module tb_alu_txn_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: SETTLE=1, CNT_W=16
    logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y, err_cnt;
    logic [1:0]  cmd_op, alu_op;
    logic        alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less;
    logic [4:0]  rsp_flags;
    logic [15:0] txn_cnt;

    // Second instance: SETTLE=3, CNT_W=4
    logic        s3_rst, s3_cmd_valid, s3_cmd_ready, s3_rsp_valid, s3_rsp_ready, s3_rsp_err;
    logic [7:0]  s3_cmd_a, s3_cmd_b, s3_alu_a, s3_alu_b, s3_alu_y, s3_rsp_y, s3_err_cnt;
    logic [1:0]  s3_cmd_op, s3_alu_op;
    logic [4:0]  s3_rsp_flags;
    logic [3:0]  s3_txn_cnt;

    alu_txn_driver #(.SETTLE(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
        .alu_greater(alu_greater), .alu_is_eq(alu_is_eq), .alu_less(alu_less),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .txn_cnt(txn_cnt), .err_cnt(err_cnt)
    );

    alu_txn_driver #(.SETTLE(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(s3_rst),
        .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready),
        .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_op(s3_cmd_op),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_op(s3_alu_op),
        .alu_y(s3_alu_y), .alu_parity(1'b0), .alu_overflow(1'b0),
        .alu_greater(1'b0), .alu_is_eq(1'b1), .alu_less(1'b0),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready),
        .rsp_y(s3_rsp_y), .rsp_flags(s3_rsp_flags), .rsp_err(s3_rsp_err),
        .txn_cnt(s3_txn_cnt), .err_cnt(s3_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [4:0] f);
        {alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less} = f;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 2'b00; alu_y = 8'h00; set_flags(5'b00000);
        s3_rst = 1'b1; s3_cmd_valid = 1'b0; s3_rsp_ready = 1'b0;
        s3_cmd_a = 8'h00; s3_cmd_b = 8'h00; s3_cmd_op = 2'b00; s3_alu_y = 8'hFF;
        step(); step();

        // Reset state
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'h00);
        check("rst_rsp_flags", {27'd0, rsp_flags}, 32'h00);
        check("rst_txn_cnt", {16'd0, txn_cnt}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0; s3_rst = 1'b0;
        step();

        // Basic transaction, SETTLE=1
        alu_y = 8'h46; set_flags(5'b01001);
        cmd_valid = 1'b1; cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 2'b00; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("t1_alu_a", {24'd0, alu_a}, 32'h12);
        check("t1_alu_b", {24'd0, alu_b}, 32'h34);
        check("t1_wait_ready", {31'd0, cmd_ready}, 32'd0);
        check("t1_wait_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_rsp_y", {24'd0, rsp_y}, 32'h46);
        check("t1_rsp_flags", {27'd0, rsp_flags}, 32'h09);
        check("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
        step();
        check("t1_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("t1_txn_cnt", {16'd0, txn_cnt}, 32'd1);
        check("t1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t1_alu_a_hold", {24'd0, alu_a}, 32'h12);

        // Back-pressure in RESP
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = 2'b11;
        alu_y = 8'h5A; set_flags(5'b00100);
        step();
        check("bp_alu_op", {30'd0, alu_op}, 32'd3);
        cmd_a = 8'h77; cmd_b = 8'h88; cmd_op = 2'b01;
        step();
        check("bp_cap_y", {24'd0, rsp_y}, 32'h5A);
        alu_y = 8'h00; set_flags(5'b11010);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_y", {24'd0, rsp_y}, 32'h5A);
            check("bp_rsp_flags", {27'd0, rsp_flags}, 32'h04);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_alu_a", {24'd0, alu_a}, 32'hAA);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_hs_ready", {31'd0, cmd_ready}, 32'd1);
        check("bp_txn_cnt", {16'd0, txn_cnt}, 32'd2);

        // Next command accepted; inconsistent flags (greater+is_eq)
        set_flags(5'b00110); alu_y = 8'h33;
        step();
        cmd_valid = 1'b0;
        check("err_alu_a", {24'd0, alu_a}, 32'h77);
        step();
        check("err_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("err_rsp_flags", {27'd0, rsp_flags}, 32'h06);
        step();
        check("err_cnt_1", {24'd0, err_cnt}, 32'd1);
        check("err_txn_cnt", {16'd0, txn_cnt}, 32'd3);

        // 256 back-to-back erroneous transactions -> err_cnt saturates
        cmd_valid = 1'b1;
        for (int i = 0; i < 256 * 3; i++) step();
        cmd_valid = 1'b0;
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
        check("sat_txn_cnt", {16'd0, txn_cnt}, 32'd259);
        set_flags(5'b10000);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("zero_hot_err", {31'd0, rsp_err}, 32'd1);
        step();
        check("sat_hold", {24'd0, err_cnt}, 32'd255);

        // Reset during WAIT
        set_flags(5'b00001);
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_a = 8'hC3;
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rw_alu_a", {24'd0, alu_a}, 32'h00);
        check("rw_valid", {31'd0, rsp_valid}, 32'd0);
        check("rw_txn_cnt", {16'd0, txn_cnt}, 32'd0);
        check("rw_err_cnt", {24'd0, err_cnt}, 32'd0);
        #1 rst = 1'b0;
        step(); step();
        check("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rw_idle", {31'd0, cmd_ready}, 32'd1);

        // Reset during RESP
        cmd_valid = 1'b1; cmd_a = 8'h5C;
        step();
        cmd_valid = 1'b0;
        step();
        check("rr_pre_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("rr_valid", {31'd0, rsp_valid}, 32'd0);
        check("rr_alu_a", {24'd0, alu_a}, 32'h00);
        check("rr_rsp_y", {24'd0, rsp_y}, 32'h00);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        step(); step(); step();
        check("rr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rr_txn_cnt", {16'd0, txn_cnt}, 32'd0);

        // SETTLE=3: result changes two cycles after drive, captured on the third edge
        s3_cmd_valid = 1'b1; s3_cmd_a = 8'h0A; s3_rsp_ready = 1'b1; s3_alu_y = 8'hFF;
        step();
        s3_cmd_valid = 1'b0;
        check("s3_alu_a", {24'd0, s3_alu_a}, 32'h0A);
        check("s3_ready_w0", {31'd0, s3_cmd_ready}, 32'd0);
        step();
        check("s3_ready_w1", {31'd0, s3_cmd_ready}, 32'd0);
        check("s3_valid_w1", {31'd0, s3_rsp_valid}, 32'd0);
        step();
        s3_alu_y = 8'h0F;
        check("s3_ready_w2", {31'd0, s3_cmd_ready}, 32'd0);
        check("s3_valid_w2", {31'd0, s3_rsp_valid}, 32'd0);
        step();
        check("s3_valid", {31'd0, s3_rsp_valid}, 32'd1);
        check("s3_rsp_y", {24'd0, s3_rsp_y}, 32'h0F);
        check("s3_rsp_err", {31'd0, s3_rsp_err}, 32'd0);
        step();
        check("s3_txn_1", {28'd0, s3_txn_cnt}, 32'd1);

        // 16 more back-to-back transactions (5 cycles each) wrap the 4-bit counter
        s3_cmd_valid = 1'b1;
        for (int i = 0; i < 16 * 5; i++) step();
        s3_cmd_valid = 1'b0;
        check("s3_wrap_txn", {28'd0, s3_txn_cnt}, 32'd1);
        check("s3_wrap_idle", {31'd0, s3_cmd_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_txn_driver.md
Name: alu_txn_driver

Overview:
- Initiator side of the 8-bit combinational ALU port (a, b, op -> y, parity, overflow, greater, is_eq, less).
- Accepts operation commands from an upstream valid/ready stream and drives registered operands into the ALU.
- Waits a fixed settle time, then captures the result and all flags into a response register.
- Returns the response on a downstream valid/ready stream, with flag-consistency checking and transaction/error counters.

Parameters:
- SETTLE, 1, cycles from operand drive to result capture; legal range 1..15; 0 is illegal.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  upstream command valid
- cmd_ready  output  1  block can accept a command
- cmd_a  input  8  operand a
- cmd_b  input  8  operand b
- cmd_op  input  2  ALU opcode, passed through unchanged
- alu_a  output  8  registered operand to ALU
- alu_b  output  8  registered operand to ALU
- alu_op  output  2  registered opcode to ALU
- alu_y  input  8  ALU result
- alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less  input  1 each  ALU flags
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream accepts response
- rsp_y  output  8  captured result
- rsp_flags  output  5  captured {parity, overflow, greater, is_eq, less}, MSB first
- rsp_err  output  1  captured compare flags inconsistent
- txn_cnt  output  CNT_W  completed responses, wraps
- err_cnt  output  8  responses with rsp_err=1, saturates at 255

Behaviour:
- Reset (async, any state): state=IDLE. alu_a=alu_b=0, alu_op=0. rsp_valid=0, rsp_y=0, rsp_flags=0, rsp_err=0, txn_cnt=0, err_cnt=0. Any in-flight transaction is discarded with no response.
- States:
  - IDLE: cmd_ready=1. On cmd_valid=1, register cmd_a/b/op into alu_a/b/op at the edge, load settle counter with SETTLE-1, go to WAIT.
  - WAIT: cmd_ready=0. Counter decrements each cycle. At the edge where counter==0, capture alu_y, the flags and rsp_err into the rsp_* registers, set rsp_valid=1, go to RESP. With SETTLE=1, capture occurs one edge after the accept edge.
  - RESP: cmd_ready=0. rsp_valid and all rsp_* are held stable while rsp_ready=0. On an edge with rsp_ready=1: rsp_valid->0, txn_cnt+1, err_cnt+1 if rsp_err=1 (held at 255), go to IDLE.
- Latency: command accepted at edge N -> rsp_valid high after edge N+SETTLE.
- Throughput: with rsp_ready tied high, one transaction per SETTLE+2 cycles.
- alu_a/b/op change only on a command accept; they hold their last value in every other state, including after the response completes.
- rsp_err = 1 iff greater+is_eq+less != 1, evaluated on the captured flags.
- rsp_y and rsp_flags are not modified on the response handshake; they hold until the next capture.
- cmd_valid in WAIT or RESP is ignored; upstream holds it per valid/ready rules.
- cmd_a/b/op are sampled only on the accept edge.
- txn_cnt wraps from 2^CNT_W-1 to 0.
- rst asserted during RESP clears rsp_valid immediately (async); counters do not increment.

Test Plan:
- Reset, then send cmd a=8'h12, b=8'h34, op=2'b00 with SETTLE=1 and ALU model returning y=8'h46, flags {0,1,0,0,1}, rsp_ready=1 -> alu_a=8'h12 one edge after accept; rsp_valid after the next edge with rsp_y=8'h46, rsp_flags=5'b01001, rsp_err=0; txn_cnt=1.
- SETTLE=3, model changes alu_y from 8'hFF to 8'h0F two cycles after drive -> rsp_y=8'h0F captured 3 edges after accept; cmd_ready=0 throughout WAIT.
- rsp_ready held 0 for 5 cycles in RESP, with cmd_valid=1 and new operands applied -> rsp_* stable, cmd_ready=0, alu_a unchanged; handshake on cycle 6 -> back to IDLE, new command accepted next edge.
- Model drives greater=1, is_eq=1, less=0 -> rsp_err=1, err_cnt increments by 1 on the handshake; preload 255 errors -> err_cnt stays 255.
- Assert rst while in WAIT and again while in RESP -> rsp_valid=0 immediately, alu_*=0, counters=0, no spurious response after rst deasserts.
- Issue 65537 back-to-back transactions with CNT_W=16 -> txn_cnt=1 after wrap.
